// File: rtl/spi_master_engine_if.sv
// Request/response bundle between a host and the SPI register-access engine.
interface spi_master_engine_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (output start, rw, addr, wdata, input busy, done, rdata);
  modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_master_engine.sv
// SPI mode-0 master issuing one 16-bit {addr,rw,data} frame per request;
// all pin outputs and status flags are registered.
module spi_master_engine #(
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned GAP      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_engine_if.slave   bus,
  output logic                 sclk_pin,
  output logic                 cs_pin,
  output logic                 mosi_pin,
  input  logic                 miso_pin
);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_B   = (CS_HOLD > GAP) ? CS_HOLD : GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_t         r_state, w_state;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic           r_phase, w_phase;
  logic [3:0]     r_bit, w_bit;
  logic [15:0]    r_frame, w_frame;
  logic           r_rw, w_rw;
  logic [7:0]     r_shadow, w_shadow;
  logic [7:0]     r_rdata, w_rdata;
  logic           r_busy, w_busy;
  logic           r_done, w_done;
  logic           r_sclk, w_sclk;
  logic           r_cs, w_cs;
  logic           r_mosi, w_mosi;
  logic           r_miso_s1, r_miso_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso_pin;
      r_miso_s2 <= r_miso_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_bit    <= '0;
      r_frame  <= '0;
      r_rw     <= 1'b0;
      r_shadow <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs     <= 1'b1;
      r_mosi   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_phase  <= w_phase;
      r_bit    <= w_bit;
      r_frame  <= w_frame;
      r_rw     <= w_rw;
      r_shadow <= w_shadow;
      r_rdata  <= w_rdata;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_sclk   <= w_sclk;
      r_cs     <= w_cs;
      r_mosi   <= w_mosi;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt + CW'(1);
    w_phase  = r_phase;
    w_bit    = r_bit;
    w_frame  = r_frame;
    w_rw     = r_rw;
    w_shadow = r_shadow;
    w_rdata  = r_rdata;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_sclk   = r_sclk;
    w_cs     = r_cs;
    w_mosi   = r_mosi;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt = '0;
        if (bus.start) begin
          w_state  = ST_SETUP;
          w_frame  = {bus.addr, bus.rw, (bus.rw ? 8'h00 : bus.wdata)};
          w_rw     = bus.rw;
          w_shadow = '0;
          w_phase  = 1'b0;
          w_bit    = '0;
          w_busy   = 1'b1;
          w_cs     = 1'b0;
          w_mosi   = bus.addr[6];
        end
      end
      ST_SETUP: begin
        if (r_cnt == CW'(CS_SETUP - 1)) begin
          w_state = ST_SHIFT;
          w_cnt   = '0;
          w_phase = 1'b0;
          w_bit   = '0;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CW'(CLK_DIV - 1)) begin
          w_cnt = '0;
          if (!r_phase) begin
            // Rising edge; only the last eight bit periods carry read data.
            w_phase = 1'b1;
            w_sclk  = 1'b1;
            if (r_bit[3])
              w_shadow = {r_shadow[6:0], r_miso_s2};
          end else begin
            w_phase = 1'b0;
            w_sclk  = 1'b0;
            if (r_bit == 4'd15) begin
              w_state = ST_HOLD;
              w_mosi  = 1'b0;
            end else begin
              w_bit   = r_bit + 4'd1;
              w_frame = {r_frame[14:0], 1'b0};
              w_mosi  = r_frame[14];
            end
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt == CW'(CS_HOLD - 1)) begin
          w_state = ST_GAP;
          w_cnt   = '0;
          w_cs    = 1'b1;
          w_done  = 1'b1;
          if (r_rw)
            w_rdata = r_shadow;
        end
      end
      ST_GAP: begin
        if (r_cnt == CW'(GAP - 1)) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
          w_busy  = 1'b0;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;
  assign sclk_pin  = r_sclk;
  assign cs_pin    = r_cs;
  assign mosi_pin  = r_mosi;

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine with a bit-level SPI memory slave model.
module tb_spi_master_engine;
  localparam int unsigned D = 4, S = 2, H = 2, G = 4;
  // done is registered on edge T+132 and therefore sampled by edge T+133.
  localparam int EXP_LAT = 1 + S + 32 * D + H - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miso = 1'b0;
  logic sclk_pin, cs_pin, mosi_pin;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  spi_master_engine_if bus_if ();

  spi_master_engine #(.CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave),
    .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin), .miso_pin(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: mode 0, captures on sclk rise, drives read data on sclk fall.
  logic [7:0]  mem [128];
  logic        fixed_en = 1'b0;
  logic [7:0]  fixed_val = 8'h00;
  logic [15:0] srx = '0, last_frame = '0;
  logic [7:0]  stx = '0;
  logic        p_sclk = 1'b0;
  int          sbits = 0, rises = 0, frames = 0, viol = 0, dcnt = 0;

  always @(negedge clk) begin
    if (cs_pin && (sclk_pin || mosi_pin)) viol++;
    if (bus_if.done) dcnt++;
    if (cs_pin) begin
      sbits = 0;
    end else begin
      if (sclk_pin && !p_sclk) begin
        srx = {srx[14:0], mosi_pin};
        sbits++;
        rises++;
        if (sbits == 8 && srx[0]) stx = fixed_en ? fixed_val : mem[srx[7:1]];
        if (sbits == 16) begin
          last_frame = srx;
          frames++;
          if (!srx[8]) mem[srx[15:9]] = srx[7:0];
        end
      end
      if (!sclk_pin && p_sclk && sbits >= 8 && sbits < 16) begin
        miso = stx[7];
        stx  = {stx[6:0], 1'b0};
      end
    end
    p_sclk = sclk_pin;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int   t0, lat;
  logic got, cs_at_done;

  // One request; optionally re-pulses start pulse_at cycles after acceptance.
  task automatic run_txn(input logic rw_i, input logic [6:0] a, input logic [7:0] wd,
                         input int pulse_at);
    int n;
    n = 0;
    while (bus_if.busy && n < 200) begin @(posedge clk); #1; n++; end
    chk("idle_before_start", {31'd0, bus_if.busy}, 0);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.rw = rw_i; bus_if.addr = a; bus_if.wdata = wd;
    @(posedge clk); #1;
    t0 = cyc;
    bus_if.start = 1'b0; bus_if.rw = ~rw_i; bus_if.addr = ~a; bus_if.wdata = ~wd;
    chk("busy_after_start", {31'd0, bus_if.busy}, 1);
    chk("cs_low_after_start", {31'd0, cs_pin}, 0);
    got = 1'b0; lat = -1; cs_at_done = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      bus_if.start = (pulse_at > 0 && cyc - t0 == pulse_at);
      if (bus_if.done) begin
        got = 1'b1; lat = cyc - t0; cs_at_done = cs_pin;
      end
    end
    bus_if.start = 1'b0;
    chk("done_seen", {31'd0, got}, 1);
    if (got) begin
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, bus_if.done}, 0);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic        fixed;
    logic [7:0]  fval;
    int          pulse_at;
    logic [15:0] frame;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [8];
  int   f0, r0, d0, n;

  initial begin
    vecs[0] = '{1'b0, 7'h05, 8'hA5, 1'b0, 8'h00, 0,  16'h0AA5, 8'h00};
    vecs[1] = '{1'b1, 7'h05, 8'h77, 1'b1, 8'h3C, 0,  16'h0B00, 8'h3C};
    vecs[2] = '{1'b0, 7'h12, 8'hFF, 1'b0, 8'h00, 50, 16'h24FF, 8'h3C};
    vecs[3] = '{1'b1, 7'h12, 8'h00, 1'b0, 8'h00, 0,  16'h2500, 8'hFF};
    vecs[4] = '{1'b0, 7'h12, 8'h00, 1'b0, 8'h00, 0,  16'h2400, 8'hFF};
    vecs[5] = '{1'b1, 7'h12, 8'hEE, 1'b0, 8'h00, 0,  16'h2500, 8'h00};
    vecs[6] = '{1'b0, 7'h7F, 8'h5A, 1'b0, 8'h00, 0,  16'hFE5A, 8'h00};
    vecs[7] = '{1'b1, 7'h7F, 8'h00, 1'b0, 8'h00, 0,  16'hFF00, 8'h5A};

    bus_if.start = 1'b0; bus_if.rw = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {31'd0, cs_pin}, 1);
    chk("rst_sclk", {31'd0, sclk_pin}, 0);
    chk("rst_mosi", {31'd0, mosi_pin}, 0);
    chk("rst_busy", {31'd0, bus_if.busy}, 0);
    chk("rst_done", {31'd0, bus_if.done}, 0);
    chk("rst_rdata", {24'd0, bus_if.rdata}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      fixed_en = vecs[v].fixed; fixed_val = vecs[v].fval;
      f0 = frames; r0 = rises;
      run_txn(vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].pulse_at);
      chk($sformatf("v%0d_latency", v), lat, EXP_LAT);
      chk($sformatf("v%0d_cs_at_done", v), {31'd0, cs_at_done}, 1);
      chk($sformatf("v%0d_rdata", v), {24'd0, bus_if.rdata}, {24'd0, vecs[v].rdata});
      chk($sformatf("v%0d_frame", v), {16'd0, last_frame}, {16'd0, vecs[v].frame});
      chk($sformatf("v%0d_sclk_rises", v), rises - r0, 16);
      repeat (12) @(posedge clk);
      #1;
      chk($sformatf("v%0d_frame_count", v), frames - f0, 1);
      chk($sformatf("v%0d_cs_idle", v), {31'd0, cs_pin}, 1);
    end
    fixed_en = 1'b0;

    // start held high: two frames separated by exactly G+1 cs-high cycles.
    f0 = frames;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.rw = 1'b0; bus_if.addr = 7'h44; bus_if.wdata = 8'h11;
    n = 0;
    while (!bus_if.done && n < 400) begin @(posedge clk); #1; n++; end
    chk("b2b_first_done", {31'd0, bus_if.done}, 1);
    n = 0;
    while (cs_pin && n < 50) begin n++; @(posedge clk); #1; end
    bus_if.start = 1'b0;
    chk("b2b_cs_high_cycles", n, G + 1);
    n = 0;
    while (!bus_if.done && n < 400) begin @(posedge clk); #1; n++; end
    chk("b2b_second_done", {31'd0, bus_if.done}, 1);
    chk("b2b_frames", frames - f0, 2);
    repeat (12) @(posedge clk);

    // Reset in the middle of a read of 7F (memory holds 5A, rdata holds 5A).
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.rw = 1'b1; bus_if.addr = 7'h7F;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (59) @(posedge clk);
    #3;
    d0 = dcnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", {31'd0, cs_pin}, 1);
    chk("midrst_sclk", {31'd0, sclk_pin}, 0);
    chk("midrst_mosi", {31'd0, mosi_pin}, 0);
    chk("midrst_busy", {31'd0, bus_if.busy}, 0);
    chk("midrst_rdata", {24'd0, bus_if.rdata}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("midrst_no_done", dcnt - d0, 0);

    // Operation resumes cleanly straight after reset release.
    f0 = frames;
    run_txn(1'b0, 7'h33, 8'hC3, 0);
    chk("post_rst_latency", lat, EXP_LAT);
    chk("post_rst_frame", {16'd0, last_frame}, 32'h0000_66C3);
    chk("post_rst_frames", frames - f0, 1);
    chk("post_rst_rdata", {24'd0, bus_if.rdata}, 0);
    chk("idle_pins_quiet", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_master_engine.md
SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: SCLK half-period in clk cycles; legal range is 2 or more.
REQ-002 SHALL have parameter CS_SETUP, default 4: clk cycles from cs_pin fall to the first SCLK low phase.
REQ-003 SHALL have parameter CS_HOLD, default 4: clk cycles from the last SCLK fall to cs_pin rise.
REQ-004 SHALL have parameter GAP, default 8: minimum clk cycles with cs_pin high between transactions.
REQ-005 SHALL have port clk, input, 1 bit: the single FPGA clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-008 SHALL have port rw, input, 1 bit: 1 = read, 0 = write; captured with start.
REQ-009 SHALL have port addr, input, 7 bits: memory address; captured with start.
REQ-010 SHALL have port wdata, input, 8 bits: write data; captured with start.
REQ-011 SHALL have port busy, output, 1 bit: high from the cycle after start acceptance until return to IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at transaction end.
REQ-013 SHALL have port rdata, output, 8 bits: read result, valid from done onward, held until the next read's done.
REQ-014 SHALL have port sclk_pin, output, 1 bit: SPI clock, idle low.
REQ-015 SHALL have port cs_pin, output, 1 bit: chip select, active low, idle high.
REQ-016 SHALL have port mosi_pin, output, 1 bit: master-out serial data.
REQ-017 SHALL have port miso_pin, input, 1 bit: master-in serial data, asynchronous to clk.

Function
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP, all as registered outputs.
REQ-019 SHALL, in IDLE with start=1 at edge T, latch {addr,rw,wdata}, enter SETUP, and drive cs_pin=0 and busy=1 from T+1.
REQ-020 SHALL form the 16-bit frame {addr[6:0], rw, data}, MSB first, where data is wdata for a write and 8'h00 for a read.
REQ-021 SHALL present frame bit 15 on mosi_pin when cs_pin falls, and stay in SETUP for CS_SETUP cycles.
REQ-022 SHALL, in SHIFT, run 16 bit periods, each CLK_DIV cycles sclk low then CLK_DIV cycles sclk high.
REQ-023 SHALL update mosi_pin to the next frame bit only at sclk falling transitions.
REQ-024 SHALL sample miso_pin, through a 2-flop synchronizer, on the clk cycle sclk rises in bit periods 9-16, shifting MSB first into rdata's shadow register.
REQ-025 SHALL, after the 16th high phase, drive sclk low and enter HOLD for CS_HOLD cycles.
REQ-026 SHALL, on leaving HOLD, drive cs_pin=1 and pulse done for exactly one cycle.
REQ-027 SHALL update rdata in the done cycle for reads and leave it unchanged for writes.
REQ-028 SHALL keep busy high through GAP for GAP cycles, then return to IDLE with busy=0.
REQ-029 SHALL assert done exactly 1+CS_SETUP+32*CLK_DIV+CS_HOLD cycles after edge T.
REQ-030 SHALL ignore start while busy=1; no queuing.
REQ-031 SHALL accept start asserted in the first IDLE cycle after GAP, with no dead cycle.
REQ-032 SHALL hold mosi_pin=0 and sclk_pin=0 whenever cs_pin=1.
REQ-033 SHALL hold input changes after acceptance with no effect on the current frame.
REQ-034 SHALL size all counters to CLK_DIV, CS_SETUP, CS_HOLD and GAP maxima with no wrap-around inside a state.
REQ-035 SHALL clear each counter on every state entry.

Reset
REQ-036 SHALL, on rst_n=0 in any state, immediately (asynchronously) force state=IDLE, cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=8'h00, and clear all counters and shift registers.
REQ-037 SHALL, on reset mid-transaction, emit no done pulse and no partial rdata update.
REQ-038 SHALL begin operation on the first clk edge after rst_n deasserts.

Verification (CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, GAP=4)
REQ-039 SHALL pass: write addr=7'h05, wdata=8'hA5 -> mosi frame 16'h0AA5, exactly 16 sclk rises, done at T+133, cs_pin high at T+133.
REQ-040 SHALL pass: read addr=7'h05 with slave model returning 8'h3C on falling edges -> frame 16'h0B00, rdata=8'h3C at done.
REQ-041 SHALL pass: start pulsed again at T+50 during a busy transaction -> ignored, a single frame only.
REQ-042 SHALL pass: start held high continuously -> back-to-back frames, cs_pin high for exactly GAP+1 cycles between them.
REQ-043 SHALL pass: rst_n low at T+60 -> cs_pin=1 and sclk_pin=0 within the same cycle, no done pulse, rdata=8'h00.
REQ-044 SHALL pass: write then read of the same address against the full memory model -> rdata equals the written value for 8'h00, 8'hFF and 8'h5A.
